// File: rtl/audio_clk_pkg.sv
// Shared constants for the audio clock path: rPLL frequency plan, default
// monitor limits, and the monitor FSM state type.
`timescale 1ns/1ps
package audio_clk_pkg;

    localparam int REF_HZ     = 27_000_000;
    localparam int PLL_VCO_HZ = 432_000_000;
    localparam int SDIV       = 88;
    localparam int MON_HZ     = PLL_VCO_HZ / SDIV;

    // Default 1 ms gate; expected count is the nominal edge count +/- 1 %.
    localparam int GATE_CYCLES_DEF  = REF_HZ / 1000;
    localparam int EXP_NOM          = MON_HZ / (REF_HZ / GATE_CYCLES_DEF);
    localparam int EXP_MIN_DEF      = EXP_NOM - EXP_NOM / 100;
    localparam int EXP_MAX_DEF      = EXP_NOM + EXP_NOM / 100;
    localparam int CNT_W_DEF        = 16;
    localparam int LOCK_WINDOWS_DEF = 4;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_MEASURE = 2'd1,
        ST_EVAL    = 2'd2
    } mon_state_e;

endpackage

// File: rtl/sync_rise_detect.sv
// Two-flop synchroniser plus history flop for an asynchronous input; emits a
// one-cycle pulse in the clk domain for each rising edge of the input.
`timescale 1ns/1ps
module sync_rise_detect (
    input  logic clk,
    input  logic rst_n,
    input  logic sig,
    output logic rise
);

    logic s1;
    logic s2;
    logic s3;

    // NOTE: non-blocking assignments make s1/s2/s3 a true shift chain; blocking ones would collapse it to one flop.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= sig;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign rise = s2 & ~s3;

endmodule

// File: rtl/pll_clk_monitor.sv
// Frequency checker for the divided PLL audio clock: counts its rising edges
// over a fixed reference-clock gate window and tracks lock over several windows.
`timescale 1ns/1ps
module pll_clk_monitor
    import audio_clk_pkg::*;
#(
    parameter int GATE_CYCLES  = GATE_CYCLES_DEF,
    parameter int CNT_W        = CNT_W_DEF,
    parameter int EXP_MIN      = EXP_MIN_DEF,
    parameter int EXP_MAX      = EXP_MAX_DEF,
    parameter int LOCK_WINDOWS = LOCK_WINDOWS_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             mon_clk,
    output logic [CNT_W-1:0] meas_count,
    output logic             meas_valid,
    output logic             in_range,
    output logic             lock,
    output logic             lock_lost
);

    localparam int GATE_W = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
    localparam int GOOD_W = $clog2(LOCK_WINDOWS + 1);

    localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);
    localparam logic [CNT_W-1:0]  CNT_MIN   = CNT_W'(EXP_MIN);
    localparam logic [CNT_W-1:0]  CNT_MAX   = CNT_W'(EXP_MAX);
    localparam logic [GOOD_W-1:0] GOOD_FULL = GOOD_W'(LOCK_WINDOWS);
    localparam logic [GOOD_W-1:0] GOOD_PRE  = GOOD_W'(LOCK_WINDOWS - 1);

    mon_state_e        state;
    logic [GATE_W-1:0] gate_cnt;
    logic [CNT_W-1:0]  edge_cnt;
    logic [GOOD_W-1:0] good_cnt;
    logic              rise;
    logic              win_good;

    sync_rise_detect u_mon_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .sig   (mon_clk),
        .rise  (rise)
    );

    assign win_good = (edge_cnt >= CNT_MIN) && (edge_cnt <= CNT_MAX);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            gate_cnt   <= '0;
            edge_cnt   <= '0;
            good_cnt   <= '0;
            meas_count <= '0;
            meas_valid <= 1'b0;
            in_range   <= 1'b0;
            lock       <= 1'b0;
            lock_lost  <= 1'b0;
        end else begin
            meas_valid <= 1'b0;
            lock_lost  <= 1'b0;

            // Disabling abandons the partial window and forgets lock history silently.
            if (!enable) begin
                state    <= ST_IDLE;
                gate_cnt <= '0;
                edge_cnt <= '0;
                good_cnt <= '0;
                lock     <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        gate_cnt <= '0;
                        edge_cnt <= '0;
                        state    <= ST_MEASURE;
                    end

                    ST_MEASURE: begin
                        if (rise && (edge_cnt != '1))
                            edge_cnt <= edge_cnt + 1'b1;
                        if (gate_cnt == GATE_LAST)
                            state <= ST_EVAL;
                        else
                            gate_cnt <= gate_cnt + 1'b1;
                    end

                    ST_EVAL: begin
                        meas_count <= edge_cnt;
                        meas_valid <= 1'b1;
                        in_range   <= win_good;
                        gate_cnt   <= '0;
                        edge_cnt   <= '0;
                        state      <= ST_MEASURE;
                        if (win_good) begin
                            if (good_cnt != GOOD_FULL)
                                good_cnt <= good_cnt + 1'b1;
                            lock <= (good_cnt >= GOOD_PRE);
                        end else begin
                            good_cnt  <= '0;
                            lock      <= 1'b0;
                            lock_lost <= lock;
                        end
                    end

                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule
